// File: rtl/validation_scheduler.sv
// Sequencer around one validator_core: per stored point it loads the test point, clears the
// validator, streams the cloud in DISTANCE_MODULES-wide batches and emits one verdict per point.

module validation_scheduler_lane #(
  parameter int          N         = 16,
  parameter int          IW        = 36,
  parameter int          LANE      = 0,
  parameter logic [N-1:0] PAD_VALUE = 16'h7FFF
) (
  input  logic [3*N-1:0] data,
  input  logic           vld,
  input  logic [IW-1:0]  base,
  input  logic [IW-1:0]  size,
  input  logic [IW-1:0]  self_idx,
  output logic [N-1:0]   x,
  output logic [N-1:0]   y,
  output logic [N-1:0]   z
);
  logic [IW-1:0] idx;
  logic          pad;

  // Out-of-cloud and self lanes get a coordinate that can never be inside the radius
  assign idx = base + IW'(LANE);
  assign pad = !vld || (idx >= size) || (idx == self_idx);
  assign x   = pad ? PAD_VALUE : data[N-1:0];
  assign y   = pad ? PAD_VALUE : data[2*N-1:N];
  assign z   = pad ? PAD_VALUE : data[3*N-1:2*N];
endmodule

module validation_scheduler #(
  parameter int           N                = 16,
  parameter int           DISTANCE_MODULES = 8,
  parameter int           DRAIN            = 4,
  parameter logic [N-1:0] PAD_VALUE        = 16'h7FFF
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          start,
  input  logic [2*N-1:0]                point_cloud_size,
  output logic                          busy,
  output logic                          done,
  output logic                          pt_rd,
  output logic [2*N-1:0]                pt_addr,
  input  logic [3*N-1:0]                pt_data,
  output logic                          batch_rd,
  output logic [2*N-1:0]                batch_addr,
  input  logic [3*N*DISTANCE_MODULES-1:0] batch_data,
  output logic                          val_reset,
  output logic [N-1:0]                  val_x,
  output logic [N-1:0]                  val_y,
  output logic [N-1:0]                  val_z,
  output logic [N*DISTANCE_MODULES-1:0] val_cp_x,
  output logic [N*DISTANCE_MODULES-1:0] val_cp_y,
  output logic [N*DISTANCE_MODULES-1:0] val_cp_z,
  output logic [2*N-1:0]                val_size,
  input  logic                          val_inlier,
  output logic                          res_valid,
  input  logic                          res_ready,
  output logic [2*N-1:0]                res_index,
  output logic                          res_inlier
);
  localparam int DM = DISTANCE_MODULES;
  localparam int AW = 2*N;
  localparam int IW = AW + $clog2(DM) + 1;
  localparam int CW = $clog2(DRAIN + 2);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_CLEAR  = 3'd2;
  localparam logic [2:0] S_STREAM = 3'd3;
  localparam logic [2:0] S_DRAIN  = 3'd4;
  localparam logic [2:0] S_EMIT   = 3'd5;
  localparam logic [2:0] S_FIN    = 3'd6;

  logic [2:0]             state_q, state_d;
  logic [AW-1:0]          p_q, p_d, i_q, i_d, b_q, b_d, addr1_q;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   res_inl_q, res_inl_d, rd1_q;
  logic [N-1:0]           vx_q, vy_q, vz_q;
  logic [DM-1:0][N-1:0]   cpx_q, cpy_q, cpz_q, lx, ly, lz;
  logic [DM-1:0][3*N-1:0] bd;
  logic [AW:0]            nb_sum;
  logic [AW-1:0]          last_b;
  logic [IW-1:0]          base;
  logic                   hit, lane_vld;

  // One spare bit keeps the ceil-divide from wrapping for the largest P
  assign nb_sum = {1'b0, p_q} + (AW+1)'(DM - 1);
  assign last_b = AW'(nb_sum / (AW+1)'(DM)) - AW'(1);

  // Verdict is ignored on the first STREAM cycle while the cleared validator settles
  assign hit = val_inlier && ((state_q == S_STREAM && b_q != '0) || state_q == S_DRAIN);

  assign busy       = (state_q != S_IDLE) && (state_q != S_FIN);
  assign done       = (state_q == S_FIN);
  assign pt_rd      = (state_q == S_LOAD) && (cnt_q == '0);
  assign pt_addr    = i_q;
  assign batch_rd   = (state_q == S_STREAM) && !hit;
  assign batch_addr = b_q;
  assign val_reset  = !((state_q == S_STREAM) || (state_q == S_DRAIN));
  assign val_x      = vx_q;
  assign val_y      = vy_q;
  assign val_z      = vz_q;
  assign val_cp_x   = cpx_q;
  assign val_cp_y   = cpy_q;
  assign val_cp_z   = cpz_q;
  assign val_size   = p_q;
  assign res_valid  = (state_q == S_EMIT);
  assign res_index  = i_q;
  assign res_inlier = res_inl_q;

  assign bd       = batch_data;
  assign base     = IW'(addr1_q) * IW'(DM);
  assign lane_vld = rd1_q && ((state_q == S_STREAM) || (state_q == S_DRAIN));

  generate
    for (genvar k = 0; k < DM; k++) begin : g_lane
      validation_scheduler_lane #(.N(N), .IW(IW), .LANE(k), .PAD_VALUE(PAD_VALUE)) u_lane (
        .data(bd[k]), .vld(lane_vld), .base(base), .size(IW'(p_q)), .self_idx(IW'(i_q)),
        .x(lx[k]), .y(ly[k]), .z(lz[k])
      );
    end
  endgenerate

  always_comb begin
    state_d   = state_q;
    p_d       = p_q;
    i_d       = i_q;
    b_d       = b_q;
    cnt_d     = cnt_q;
    res_inl_d = res_inl_q;
    case (state_q)
      S_IDLE: if (start) begin
        p_d     = point_cloud_size;
        i_d     = '0;
        cnt_d   = '0;
        state_d = (point_cloud_size == '0) ? S_FIN : S_LOAD;
      end
      S_LOAD: if (cnt_q == '0) cnt_d = CW'(1);
              else begin cnt_d = '0; state_d = S_CLEAR; end
      S_CLEAR: if (cnt_q == '0) cnt_d = CW'(1);
               else begin cnt_d = '0; b_d = '0; state_d = S_STREAM; end
      S_STREAM: begin
        if (hit) begin
          res_inl_d = 1'b1;
          state_d   = S_EMIT;
        end else if (b_q == last_b) begin
          cnt_d   = '0;
          state_d = S_DRAIN;
        end else begin
          b_d = b_q + AW'(1);
        end
      end
      S_DRAIN: begin
        if (hit) begin
          res_inl_d = 1'b1;
          state_d   = S_EMIT;
        end else if (cnt_q == CW'(DRAIN)) begin
          res_inl_d = 1'b0;
          state_d   = S_EMIT;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_EMIT: if (res_ready) begin
        i_d       = i_q + AW'(1);
        cnt_d     = '0;
        res_inl_d = 1'b0;
        state_d   = ((i_q + AW'(1)) == p_q) ? S_FIN : S_LOAD;
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      p_q       <= '0;
      i_q       <= '0;
      b_q       <= '0;
      cnt_q     <= '0;
      res_inl_q <= 1'b0;
      rd1_q     <= 1'b0;
      addr1_q   <= '0;
      vx_q      <= '0;
      vy_q      <= '0;
      vz_q      <= '0;
      cpx_q     <= {DM{PAD_VALUE}};
      cpy_q     <= {DM{PAD_VALUE}};
      cpz_q     <= {DM{PAD_VALUE}};
    end else begin
      state_q   <= state_d;
      p_q       <= p_d;
      i_q       <= i_d;
      b_q       <= b_d;
      cnt_q     <= cnt_d;
      res_inl_q <= res_inl_d;
      rd1_q     <= batch_rd;
      addr1_q   <= b_q;
      if (state_q == S_LOAD && cnt_q == CW'(1)) begin
        vx_q <= pt_data[N-1:0];
        vy_q <= pt_data[2*N-1:N];
        vz_q <= pt_data[3*N-1:2*N];
      end
      cpx_q <= lx;
      cpy_q <= ly;
      cpz_q <= lz;
    end
  end
endmodule

// File: tb/tb_validation_scheduler.sv
// Bench for validation_scheduler: point memory model, distance-threshold validator stub and a
// result scoreboard; lane contents are checked two cycles after every batch read.

module tb_validation_scheduler;
  localparam int N  = 16;
  localparam int DM = 8;
  localparam int DR = 4;
  localparam logic [N-1:0] PAD = 16'h7FFF;

  logic              clock = 1'b0, reset = 1'b1, start = 1'b0, res_ready = 1'b1;
  logic [2*N-1:0]    point_cloud_size = '0;
  logic              busy, done, pt_rd, batch_rd, val_reset, res_valid, res_inlier;
  logic              val_inlier = 1'b0;
  logic [2*N-1:0]    pt_addr, batch_addr, val_size, res_index;
  logic [3*N-1:0]    pt_data = '0;
  logic [3*N*DM-1:0] batch_data = '0;
  logic [N-1:0]      val_x, val_y, val_z;
  logic [N*DM-1:0]   val_cp_x, val_cp_y, val_cp_z;
  logic [N*DM-1:0]   padv;

  int total = 0, passed = 0, cyc = 0, cur_p = 0;
  logic [N-1:0] mx [0:15], my [0:15], mz [0:15];

  typedef struct { int idx; logic inl; int max_brd; int lat; } exp_t;
  typedef struct { int due; int b; int pt; int p; } lchk_t;
  exp_t  sb[$];
  lchk_t lq[$];

  validation_scheduler #(.N(N), .DISTANCE_MODULES(DM), .DRAIN(DR), .PAD_VALUE(PAD)) dut (
    .clock(clock), .reset(reset), .start(start), .point_cloud_size(point_cloud_size),
    .busy(busy), .done(done), .pt_rd(pt_rd), .pt_addr(pt_addr), .pt_data(pt_data),
    .batch_rd(batch_rd), .batch_addr(batch_addr), .batch_data(batch_data),
    .val_reset(val_reset), .val_x(val_x), .val_y(val_y), .val_z(val_z),
    .val_cp_x(val_cp_x), .val_cp_y(val_cp_y), .val_cp_z(val_cp_z), .val_size(val_size),
    .val_inlier(val_inlier), .res_valid(res_valid), .res_ready(res_ready),
    .res_index(res_index), .res_inlier(res_inlier)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Point memory: one-cycle read latency on both ports
  always @(posedge clock) begin
    if (pt_rd) pt_data <= {mz[pt_addr[3:0]], my[pt_addr[3:0]], mx[pt_addr[3:0]]};
    if (batch_rd)
      for (int k = 0; k < DM; k++)
        batch_data[k*3*N +: 3*N] <= {mz[{batch_addr[0], 3'(k)}], my[{batch_addr[0], 3'(k)}],
                                     mx[{batch_addr[0], 3'(k)}]};
  end

  function automatic int absd(input logic [N-1:0] a, input logic [N-1:0] b);
    return (a > b) ? int'(a - b) : int'(b - a);
  endfunction

  // Validator stub: inlier one cycle after any lane lies within L1 distance 64
  logic hit_c;
  always_comb begin
    hit_c = 1'b0;
    for (int k = 0; k < DM; k++)
      if (absd(val_cp_x[k*N +: N], val_x) + absd(val_cp_y[k*N +: N], val_y) +
          absd(val_cp_z[k*N +: N], val_z) < 64) hit_c = 1'b1;
  end
  always @(posedge clock) val_inlier <= (reset || val_reset) ? 1'b0 : hit_c;

  // Monitor: lane contents and result scoreboard
  initial begin
    int cur_pt, brd_cnt, last_brd, emit_cyc, idx;
    logic prev_rv;
    exp_t e;
    lchk_t l;
    logic [N*DM-1:0] ex, ey, ez;
    cur_pt = 0; brd_cnt = 0; last_brd = 0; emit_cyc = 0; prev_rv = 1'b0;
    forever begin
      @(negedge clock);
      if (reset) begin
        lq.delete();
        prev_rv = 1'b0;
      end else begin
        if (pt_rd) begin cur_pt = int'(pt_addr); brd_cnt = 0; end
        if (batch_rd) begin
          brd_cnt++;
          last_brd = cyc;
          lq.push_back('{cyc + 2, int'(batch_addr), cur_pt, cur_p});
        end
        if (lq.size() > 0 && lq[0].due == cyc) begin
          l = lq.pop_front();
          for (int k = 0; k < DM; k++) begin
            idx = l.b * DM + k;
            if (idx >= l.p || idx == l.pt) begin
              ex[k*N +: N] = PAD; ey[k*N +: N] = PAD; ez[k*N +: N] = PAD;
            end else begin
              ex[k*N +: N] = mx[idx]; ey[k*N +: N] = my[idx]; ez[k*N +: N] = mz[idx];
            end
          end
          total++;
          if (val_cp_x !== ex || val_cp_y !== ey || val_cp_z !== ez)
            $display("FAIL lanes pt=%0d batch=%0d got x=%h want x=%h got z=%h want z=%h",
                     l.pt, l.b, val_cp_x, ex, val_cp_z, ez);
          else passed++;
        end
        if (res_valid && !prev_rv) emit_cyc = cyc;
        prev_rv = res_valid;
        if (res_valid && res_ready) begin
          total++;
          if (sb.size() == 0) begin
            $display("FAIL unexpected_result got idx=%0d inl=%0b want none", res_index, res_inlier);
          end else begin
            e = sb.pop_front();
            if (res_index !== 32'(e.idx) || res_inlier !== e.inl)
              $display("FAIL result got idx=%0d inl=%0b want idx=%0d inl=%0b",
                       res_index, res_inlier, e.idx, e.inl);
            else passed++;
            if (e.max_brd > 0) begin
              total++;
              if (brd_cnt > e.max_brd)
                $display("FAIL batch_count idx=%0d got %0d want <=%0d", e.idx, brd_cnt, e.max_brd);
              else passed++;
            end
            if (e.lat >= 0) begin
              total++;
              if (emit_cyc - last_brd != e.lat)
                $display("FAIL outlier_latency idx=%0d got %0d want %0d", e.idx,
                         emit_cyc - last_brd, e.lat);
              else passed++;
            end
          end
        end
      end
    end
  end

  task automatic load_mem(input bit outlier);
    for (int k = 0; k < 16; k++) begin
      if (k < 10) begin
        mx[k] = 16'(100 + k); my[k] = 16'(200 + k); mz[k] = 16'(300 + k);
      end else begin
        mx[k] = outlier ? 16'd5000 : 16'd9000; my[k] = mx[k]; mz[k] = mx[k];
      end
    end
    if (outlier) begin mx[4] = 16'd5000; my[4] = 16'd5000; mz[4] = 16'd5000; end
  endtask

  task automatic kick(input int p);
    @(posedge clock); #1;
    start = 1'b1; point_cloud_size = 32'(p); cur_p = p;
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit seen);
    seen = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clock);
      if (done) begin seen = 1'b1; break; end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    total++;
    if ({busy, done, pt_rd, batch_rd, res_valid, res_inlier} !== 6'b0)
      $display("FAIL reset_ctrl got %b want 000000", {busy, done, pt_rd, batch_rd, res_valid, res_inlier});
    else passed++;
    total++;
    if (val_reset !== 1'b1) $display("FAIL reset_val_reset got %b want 1", val_reset);
    else passed++;
    total++;
    if (pt_addr !== '0 || batch_addr !== '0 || res_index !== '0)
      $display("FAIL reset_addr got %0d/%0d/%0d want 0/0/0", pt_addr, batch_addr, res_index);
    else passed++;
    total++;
    if (val_cp_x !== padv || val_cp_y !== padv || val_cp_z !== padv)
      $display("FAIL reset_lanes got %h want %h", val_cp_x, padv);
    else passed++;
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  task automatic test_empty;
    int act;
    act = 0;
    kick(0);
    @(negedge clock);
    total++;
    if (done !== 1'b1 || busy !== 1'b0) $display("FAIL empty_done got done=%b busy=%b want 1/0", done, busy);
    else passed++;
    for (int c = 0; c < 6; c++) begin
      @(negedge clock);
      if (done || res_valid || pt_rd || batch_rd) act++;
    end
    total++;
    if (act != 0) $display("FAIL empty_quiet got %0d active cycles want 0", act);
    else passed++;
  endtask

  task automatic test_cluster;
    bit seen;
    load_mem(1'b0);
    for (int k = 0; k < 10; k++) sb.push_back('{k, 1'b1, 3, -1});
    kick(10);
    @(negedge clock);
    total++;
    if (val_size !== 32'd10) $display("FAIL val_size got %0d want 10", val_size);
    else passed++;
    wait_done(2000, seen);
    total++;
    if (!seen || sb.size() != 0) $display("FAIL cluster_done got seen=%0b left=%0d want 1/0", seen, sb.size());
    else passed++;
  endtask

  task automatic test_outlier;
    bit seen;
    load_mem(1'b1);
    for (int k = 0; k < 10; k++) sb.push_back('{k, (k != 4), 0, (k == 4) ? 2 + DR : -1});
    kick(10);
    wait_done(2000, seen);
    total++;
    if (!seen || sb.size() != 0) $display("FAIL outlier_done got seen=%0b left=%0d want 1/0", seen, sb.size());
    else passed++;
  endtask

  task automatic test_backpressure;
    bit seen;
    int bad;
    load_mem(1'b0);
    @(posedge clock); #1;
    res_ready = 1'b0;
    for (int k = 0; k < 3; k++) sb.push_back('{k, 1'b1, 3, -1});
    kick(3);
    seen = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clock);
      if (res_valid) begin seen = 1'b1; break; end
    end
    total++;
    if (!seen) $display("FAIL bp_first_valid got none want res_valid within 200 cycles");
    else passed++;
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      if (res_valid !== 1'b1 || res_index !== '0 || res_inlier !== 1'b1 || pt_rd !== 1'b0) bad++;
    end
    total++;
    if (bad != 0) $display("FAIL bp_hold got %0d unstable cycles want 0", bad);
    else passed++;
    @(posedge clock); #1;
    res_ready = 1'b1;
    wait_done(1000, seen);
    total++;
    if (!seen || sb.size() != 0) $display("FAIL bp_done got seen=%0b left=%0d want 1/0", seen, sb.size());
    else passed++;
  endtask

  task automatic test_reset_midrun;
    bit seen;
    int act;
    load_mem(1'b0);
    for (int k = 0; k < 10; k++) sb.push_back('{k, 1'b1, 3, -1});
    kick(10);
    seen = 1'b0;
    for (int c = 0; c < 500; c++) begin
      @(negedge clock);
      if (pt_addr == 32'd3 && batch_rd) begin seen = 1'b1; break; end
    end
    total++;
    if (!seen) $display("FAIL midrun_reach got none want stream of point 3");
    else passed++;
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    sb.delete();
    @(negedge clock);
    total++;
    if ({busy, done, pt_rd, batch_rd, res_valid, res_inlier, val_reset} !== 7'b0000001 ||
        pt_addr !== '0 || batch_addr !== '0 || res_index !== '0 || val_cp_x !== padv)
      $display("FAIL midrun_reset got ctrl=%b pt=%0d b=%0d idx=%0d want 0000001/0/0/0",
               {busy, done, pt_rd, batch_rd, res_valid, res_inlier, val_reset},
               pt_addr, batch_addr, res_index);
    else passed++;
    act = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      if (done || res_valid || busy) act++;
    end
    total++;
    if (act != 0) $display("FAIL midrun_quiet got %0d active cycles want 0", act);
    else passed++;
    for (int k = 0; k < 2; k++) sb.push_back('{k, 1'b1, 3, -1});
    kick(2);
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      if (pt_rd) begin seen = 1'b1; break; end
    end
    total++;
    if (!seen || pt_addr !== '0) $display("FAIL restart_index got seen=%0b addr=%0d want 1/0", seen, pt_addr);
    else passed++;
    wait_done(500, seen);
    total++;
    if (!seen || sb.size() != 0) $display("FAIL restart_done got seen=%0b left=%0d want 1/0", seen, sb.size());
    else passed++;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    padv = {DM{PAD}};
    load_mem(1'b0);
    test_reset;
    test_empty;
    test_cluster;
    test_outlier;
    test_backpressure;
    test_reset_midrun;
    repeat (3) @(negedge clock);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
